mem_wait_ctrl: RTL and testbench
================================

Name: mem_wait_ctrl

Overview:
- Unified instruction/data memory with configurable wait states for the multi-cycle RISC-V core.
- Receives the controller-selected address (PC or ALU result, chosen by AddrSrc) along with the write enable and write data.
- Returns read data for instruction fetch (IRWrite) and for load writeback.
- Emits a stall flag that the controller FSM uses to hold its memory states until the access completes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- LATENCY, 2, added wait cycles per access; legal range 0..7.
- INIT_FILE, "", hex image loaded into the array at elaboration; empty string means no preload.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; reset=0 at a rising edge resets the block
- req  input  1  access request; level, held by the controller until ready
- we  input  1  1=write, 0=read; sampled with req
- size  input  2  00=byte, 01=halfword, 10=word (funct3[1:0]); 11 is treated as word
- adr  input  32  byte address
- wd  input  32  write data, right-aligned (byte in [7:0], half in [15:0])
- rd  output  32  full aligned word read from adr[31:2]
- ready  output  1  one-cycle completion pulse
- err  output  1  misalignment flag; valid only while ready=1
- stall  output  1  access accepted but not yet complete

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE, rd=0, ready=0, err=0, stall=0, wait counter=0.
  - Any latched write is discarded.
  - Memory array contents are not cleared.
- Word index is adr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- States:
  - IDLE: if req=1, latch adr, we, size, wd; load cnt=LATENCY; go to WAIT. If LATENCY=0, go directly to ACCESS.
  - WAIT: decrement cnt each cycle. When cnt reaches 1, go to ACCESS on the next edge.
  - ACCESS: the single cycle in which the array is read or written. On the edge ending this cycle, rd and err are registered, ready is set to 1, and the state becomes RESP.
  - RESP: ready=1 for exactly this cycle; then return to IDLE.
- req is not sampled in WAIT, ACCESS or RESP. A req still high in RESP is ignored; the next request is accepted in IDLE at the earliest.
- Latency: if req is accepted in IDLE at cycle t, ACCESS occurs at cycle t+1+LATENCY and ready=1 at cycle t+2+LATENCY.
- stall=1 in WAIT and ACCESS, and in the IDLE cycle in which req=1. stall=0 in RESP and in idle cycles without req.
- Writes, by byte lane:
  - size=00: byte wd[7:0] is written to lane adr[1:0].
  - size=01: wd[15:0] is written to lanes {adr[1],0} and {adr[1],1}.
  - size=10 or 11: all four lanes are written.
  - Lanes not addressed are unchanged.
- Reads: rd is the whole word. Byte/half extraction and sign extension are done downstream. For a write, rd returns the post-write word.
- Misalignment:
  - Condition: halfword with adr[0]=1, or word with adr[1:0]!=00.
  - Effect: no write occurs, rd=0, err=1, and the full latency and ready timing still apply.
- rd and err hold their values after RESP until the next ACCESS edge or reset.
- reset=0 in any state aborts the access in that cycle. A write whose ACCESS edge coincides with reset=0 is not committed.

Test Plan:
- Reset values: hold reset=0 for 2 cycles with req=1 -> rd=0, ready=0, err=0, stall=0; no array change.
- Word write then read, LATENCY=2:
  - Write stimulus: req=1, we=1, size=10, adr=0x10, wd=0xDEADBEEF accepted at cycle t -> stall=1 for t..t+3, ready=1 only at t+4.
  - Read stimulus: read of adr=0x10 -> rd=0xDEADBEEF, err=0.
- Byte and half lanes: word 0x10=0xDEADBEEF, then sb wd=0x55 to adr=0x12 and sh wd=0x1234 to adr=0x10 -> read of 0x10 returns 0xDE551234.
- Misaligned: sh to adr=0x13, then sw to adr=0x22 -> each gets ready with err=1 and rd=0; words 0x10 and 0x20 are unchanged.
- Abort and wrap:
  - Abort: reset=0 during WAIT of a write 0xCAFEF00D to 0x40 -> returns to IDLE and a read of 0x40 returns the old value.
  - Wrap: DEPTH_WORDS=256 and write to 0x400 -> aliases to adr 0x000.
- LATENCY=0 back-to-back: req held high -> ready at t+2 and t+5; the req high in RESP is not double-accepted.

Source files
------------

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - unified I/D memory with programmable wait states and stall/ready handshake
module mem_wait_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  LAT3 = 3'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;
    logic          w_accept;

    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic          r_we;
    logic [31:0]   r_wd;

    logic [31:0]   r_rd;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [31:0]   w_old;
    logic [31:0]   w_wdata;
    logic [31:0]   w_merged;
    logic [3:0]    w_be;
    logic          w_misaligned;
    logic          w_commit;
    logic          w_unused_adr;

    // Upper address bits alias onto the array by design.
    assign w_unused_adr = ^adr[31:AW+2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = LAT3;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_idx   <= '0;
            r_lane  <= 2'd0;
            r_size  <= 2'd0;
            r_we    <= 1'b0;
            r_wd    <= 32'd0;
            r_rd    <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx  <= adr[AW+1:2];
                r_lane <= adr[1:0];
                r_size <= size;
                r_we   <= we;
                r_wd   <= wd;
            end
            if (r_state == S_ACCESS) begin
                r_err <= w_misaligned;
                if (w_misaligned) begin
                    r_rd <= 32'd0;
                end else if (r_we) begin
                    r_rd <= w_merged;
                end else begin
                    r_rd <= w_old;
                end
            end
        end
    end

    // Byte enables and lane-replicated write data; size[1] covers both 10 and 11.
    always_comb begin
        w_old        = r_mem[r_idx];
        w_be         = 4'b0000;
        w_wdata      = r_wd;
        w_misaligned = 1'b0;
        if (r_size[1]) begin
            w_be         = 4'b1111;
            w_wdata      = r_wd;
            w_misaligned = (r_lane != 2'b00);
        end else if (r_size[0]) begin
            w_be         = r_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata      = {2{r_wd[15:0]}};
            w_misaligned = r_lane[0];
        end else begin
            w_be         = 4'b0001 << r_lane;
            w_wdata      = {4{r_wd[7:0]}};
            w_misaligned = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : w_old[8*i +: 8];
        end
    end

    // A reset landing on the ACCESS edge suppresses the commit.
    assign w_commit = reset && (r_state == S_ACCESS) && r_we && !w_misaligned;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd    = r_rd;
    assign err   = r_err;
    assign ready = (r_state == S_RESP);
    assign stall = reset && (((r_state == S_IDLE) && req) ||
                             (r_state == S_WAIT) || (r_state == S_ACCESS));

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb/tb_mem_wait_ctrl.sv - directed bench for mem_wait_ctrl at LATENCY=2 and LATENCY=0
module tb_mem_wait_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [1:0]  size;
    logic [31:0] adr, wd, rd;
    logic        ready, err, stall;

    logic        req0, we0;
    logic [1:0]  size0;
    logic [31:0] adr0, wd0, rd0;
    logic        ready0, err0, stall0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wait_ctrl #(.DEPTH_WORDS(256), .LATENCY(2), .INIT_FILE("")) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .adr(adr),
        .wd(wd), .rd(rd), .ready(ready), .err(err), .stall(stall)
    );

    mem_wait_ctrl #(.DEPTH_WORDS(256), .LATENCY(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0), .adr(adr0),
        .wd(wd0), .rd(rd0), .ready(ready0), .err(err0), .stall(stall0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdo, output logic erro,
                          output int cyc, output logic [15:0] sm);
        req = 1'b1; we = w; size = s; adr = a; wd = d;
        cyc = 0;
        sm  = '0;
        #1;
        sm[0] = stall;
        while (ready !== 1'b1 && cyc < 12) begin
            step();
            cyc++;
            sm[cyc[3:0]] = stall;
        end
        rdo  = rd;
        erro = err;
        req  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h10; wd = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h exp=%h", rd, 32'd0); end
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        end
        reset = 1'b1; req = 1'b0;
        step();
    endtask

    task automatic test_word();
        logic [31:0] r; logic e; int c; logic [15:0] sm;
        access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, r, e, c, sm);
        total++; if (c !== 4) begin bad++; $display("FAIL word_latency got=%0d exp=4", c); end
        total++; if (sm[4:0] !== 5'b01111) begin bad++; $display("FAIL word_stall got=%b exp=01111", sm[4:0]); end
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL word_wr_rd got=%h exp=deadbeef", r); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL word_ready_pulse got=%b exp=0", ready); end
        access(1'b0, 2'b10, 32'h10, 32'h0, r, e, c, sm);
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL word_read got=%h exp=deadbeef", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL word_err got=%b exp=0", e); end
    endtask

    task automatic test_lanes();
        logic [31:0] r; logic e; int c; logic [15:0] sm;
        access(1'b1, 2'b00, 32'h12, 32'hFFFFFF55, r, e, c, sm);
        total++; if (r !== 32'hDE55BEEF) begin bad++; $display("FAIL sb_rd got=%h exp=de55beef", r); end
        access(1'b1, 2'b01, 32'h10, 32'hABCD1234, r, e, c, sm);
        total++; if (r !== 32'hDE551234) begin bad++; $display("FAIL sh_rd got=%h exp=de551234", r); end
        access(1'b0, 2'b10, 32'h10, 32'h0, r, e, c, sm);
        total++; if (r !== 32'hDE551234) begin bad++; $display("FAIL lanes_read got=%h exp=de551234", r); end
    endtask

    task automatic test_misaligned();
        logic [31:0] r; logic e; int c; logic [15:0] sm;
        access(1'b1, 2'b10, 32'h20, 32'hA5A5A5A5, r, e, c, sm);
        access(1'b1, 2'b01, 32'h13, 32'h0000FFFF, r, e, c, sm);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL mis_sh_err got=%b exp=1", e); end
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mis_sh_rd got=%h exp=0", r); end
        total++; if (c !== 4) begin bad++; $display("FAIL mis_sh_latency got=%0d exp=4", c); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err_hold got=%b exp=1", err); end
        access(1'b1, 2'b11, 32'h22, 32'h12345678, r, e, c, sm);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL mis_sw_err got=%b exp=1", e); end
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mis_sw_rd got=%h exp=0", r); end
        access(1'b0, 2'b10, 32'h10, 32'h0, r, e, c, sm);
        total++; if (r !== 32'hDE551234) begin bad++; $display("FAIL mis_keep10 got=%h exp=de551234", r); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mis_err_clear got=%b exp=0", err); end
        access(1'b0, 2'b10, 32'h20, 32'h0, r, e, c, sm);
        total++; if (r !== 32'hA5A5A5A5) begin bad++; $display("FAIL mis_keep20 got=%h exp=a5a5a5a5", r); end
    endtask

    task automatic test_abort();
        logic [31:0] r; logic e; int c; logic [15:0] sm;
        access(1'b1, 2'b10, 32'h40, 32'h11111111, r, e, c, sm);
        req = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h40; wd = 32'hCAFEF00D;
        step();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL abort_wait_stall got=%b exp=1", stall); end
        reset = 1'b0;
        step();
        reset = 1'b1; req = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", ready); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL abort_stall got=%b exp=0", stall); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_rd got=%h exp=0", rd); end
        step();
        access(1'b0, 2'b10, 32'h40, 32'h0, r, e, c, sm);
        total++; if (r !== 32'h11111111) begin bad++; $display("FAIL abort_wait_keep got=%h exp=11111111", r); end
        req = 1'b1; we = 1'b1; size = 2'b10; adr = 32'h40; wd = 32'hCAFEF00D;
        step(); step(); step();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL abort_access_stall got=%b exp=1", stall); end
        reset = 1'b0;
        step();
        reset = 1'b1; req = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_access_ready got=%b exp=0", ready); end
        step();
        access(1'b0, 2'b10, 32'h40, 32'h0, r, e, c, sm);
        total++; if (r !== 32'h11111111) begin bad++; $display("FAIL abort_access_keep got=%h exp=11111111", r); end
    endtask

    task automatic test_wrap();
        logic [31:0] r; logic e; int c; logic [15:0] sm;
        access(1'b1, 2'b10, 32'h400, 32'h0BADF00D, r, e, c, sm);
        access(1'b0, 2'b10, 32'h000, 32'h0, r, e, c, sm);
        total++; if (r !== 32'h0BADF00D) begin bad++; $display("FAIL wrap_400 got=%h exp=0badf00d", r); end
        access(1'b1, 2'b10, 32'h3FC, 32'h76543210, r, e, c, sm);
        access(1'b0, 2'b10, 32'hFFFFFFFC, 32'h0, r, e, c, sm);
        total++; if (r !== 32'h76543210) begin bad++; $display("FAIL wrap_top got=%h exp=76543210", r); end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  rm;
        logic [6:0]  sm;
        logic [31:0] rdcap;
        rm = '0; sm = '0; rdcap = 32'd0;
        req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; adr0 = 32'h8; wd0 = 32'h12345678;
        for (int i = 0; i < 7; i++) begin
            #1;
            rm[i] = ready0;
            sm[i] = stall0;
            if (ready0 === 1'b1) rdcap = rd0;
            step();
        end
        req0 = 1'b0;
        step(); step(); step();
        total++; if (rm !== 7'b0100100) begin bad++; $display("FAIL b2b_ready got=%b exp=0100100", rm); end
        total++; if (sm !== 7'b1011011) begin bad++; $display("FAIL b2b_stall got=%b exp=1011011", sm); end
        total++; if (rdcap !== 32'h12345678) begin bad++; $display("FAIL b2b_rd got=%h exp=12345678", rdcap); end
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", ready0); end
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; adr = 32'd0; wd = 32'd0;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; adr0 = 32'd0; wd0 = 32'd0;
        test_reset();
        test_word();
        test_lanes();
        test_misaligned();
        test_abort();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
